// File: rtl/sram_controller_if.sv
// Pipeline-side access bus for sram_controller.
//
// Macros: none.
//
// Signals:
//   rdEn, wrEn  - read / write request from the MEM stage (memRead / memWrite)
//   address     - byte address from the ALU
//   writeData   - store data
//   readData    - load data, valid while ready=1 after a read
//   ready       - 0 = access in flight, the pipeline freezes
//
// Handshake: a request is accepted on any rising edge where the controller
// is idle and rdEn|wrEn is high. ready then stays low until the single cycle
// in which the access completes; the pipeline advances on that edge. While
// ready is low the request inputs are don't-care. This is a freeze-style
// ready: it is not a valid/ready pair in which either side may stall.
//
// Modports:
//   master - pipeline side (drives the request, sees readData/ready)
//   slave  - controller side
interface sram_controller_if;
  logic        rdEn;
  logic        wrEn;
  logic [31:0] address;
  logic [31:0] writeData;
  logic [31:0] readData;
  logic        ready;

  modport master (
    output rdEn, wrEn, address, writeData,
    input  readData, ready
  );

  modport slave (
    input  rdEn, wrEn, address, writeData,
    output readData, ready
  );
endinterface

// File: rtl/sram_controller.sv
// sram_controller
//
// Turns one 32-bit data-memory access from the MEM stage into two half-word
// phases on a 16-bit asynchronous SRAM: first the low half, then the high
// half. Each phase is held for WAIT_CYCLES+1 cycles. ready is low while the
// access is in flight.
//
// Macros: SRAM_STATS_EN - when defined, adds the readCount/writeCount outputs
//                         (saturating 16-bit counts of completed accesses).
//
// Parameters:
//   BASE_ADDR    - byte address of data-memory word 0
//   WAIT_CYCLES  - extra cycles each half-word phase is held
//   SRAM_ADDR_W  - SRAM half-word address width
//
// Ports:
//   clk, rst     - rising-edge clock, synchronous active-high reset
//   bus          - pipeline access bus (sram_controller_if.slave)
//   sramAddr     - SRAM half-word address, {word index, half}
//   sramDqOut    - write data to the SRAM
//   sramDqIn     - read data from the SRAM
//   sramDqOe     - 1 = drive sramDqOut onto the DQ pins
//   sramWeN, sramOeN, sramCeN, sramUbN, sramLbN - active-low SRAM strobes
//   dbg_state    - current FSM state (0 IDLE, 1 LOW, 2 HIGH, 3 DONE)
//   readCount, writeCount - completed reads / writes (SRAM_STATS_EN only)
module sram_controller #(
  parameter int unsigned BASE_ADDR   = 1024,
  parameter int unsigned WAIT_CYCLES = 1,
  parameter int unsigned SRAM_ADDR_W = 18
) (
  input  logic                   clk,
  input  logic                   rst,
  sram_controller_if.slave       bus,
  output logic [SRAM_ADDR_W-1:0] sramAddr,
  output logic [15:0]            sramDqOut,
  input  logic [15:0]            sramDqIn,
  output logic                   sramDqOe,
  output logic                   sramWeN,
  output logic                   sramOeN,
  output logic                   sramCeN,
  output logic                   sramUbN,
  output logic                   sramLbN,
  output logic [1:0]             dbg_state
`ifdef SRAM_STATS_EN
  ,
  output logic [15:0]            readCount,
  output logic [15:0]            writeCount
`endif
);

  localparam int CW = (WAIT_CYCLES > 0) ? $clog2(WAIT_CYCLES + 1) : 1;
  localparam logic [CW-1:0] LAST = CW'(WAIT_CYCLES);
  localparam logic [31:0]   BASE = 32'(BASE_ADDR);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOW  = 2'd1,
    HIGH = 2'd2,
    DONE = 2'd3
  } state_t;

  state_t                 state;
  logic [CW-1:0]          cnt;
  logic                   op_wr;
  logic [SRAM_ADDR_W-2:0] word_q;
  logic [15:0]            wdata_hi;
  logic [31:0]            read_data_q;
  logic [31:0]            byte_off;
  logic                   req;

  // Offset from the data-memory base; the word index is taken from bit 2
  // upward, so address[1:0] drops out and out-of-range addresses wrap.
  assign byte_off = bus.address - BASE;
  assign req      = bus.rdEn | bus.wrEn;

  assign bus.ready    = (state == DONE) | ((state == IDLE) & ~req);
  assign bus.readData = read_data_q;
  assign dbg_state    = state;

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      cnt         <= '0;
      op_wr       <= 1'b0;
      word_q      <= '0;
      wdata_hi    <= '0;
      read_data_q <= '0;
      sramAddr    <= '0;
      sramDqOut   <= '0;
      sramDqOe    <= 1'b0;
      sramWeN     <= 1'b1;
      sramOeN     <= 1'b1;
      sramCeN     <= 1'b1;
      sramUbN     <= 1'b1;
      sramLbN     <= 1'b1;
`ifdef SRAM_STATS_EN
      readCount   <= '0;
      writeCount  <= '0;
`endif
    end else begin
      case (state)
        IDLE: begin
          if (req) begin
            // Write wins when both requests are raised together.
            op_wr     <= bus.wrEn;
            word_q    <= byte_off[SRAM_ADDR_W:2];
            wdata_hi  <= bus.writeData[31:16];
            cnt       <= '0;
            state     <= LOW;
            // Strobes are registered, so the low phase is set up here.
            sramAddr  <= {byte_off[SRAM_ADDR_W:2], 1'b0};
            sramDqOut <= bus.wrEn ? bus.writeData[15:0] : 16'h0000;
            sramDqOe  <= bus.wrEn;
            sramWeN   <= ~bus.wrEn;
            sramOeN   <= bus.wrEn;
            sramCeN   <= 1'b0;
            sramUbN   <= 1'b0;
            sramLbN   <= 1'b0;
          end
        end

        LOW: begin
          if (cnt == LAST) begin
            cnt      <= '0;
            state    <= HIGH;
            sramAddr <= {word_q, 1'b1};
            if (op_wr) begin
              sramDqOut <= wdata_hi;
            end else begin
              read_data_q[15:0] <= sramDqIn;
            end
          end else begin
            cnt <= cnt + 1'b1;
          end
        end

        HIGH: begin
          if (cnt == LAST) begin
            cnt      <= '0;
            state    <= DONE;
            sramDqOe <= 1'b0;
            sramWeN  <= 1'b1;
            sramOeN  <= 1'b1;
            sramCeN  <= 1'b1;
            sramUbN  <= 1'b1;
            sramLbN  <= 1'b1;
            if (!op_wr) begin
              read_data_q[31:16] <= sramDqIn;
            end
`ifdef SRAM_STATS_EN
            if (op_wr) begin
              if (writeCount != 16'hFFFF) writeCount <= writeCount + 16'd1;
            end else begin
              if (readCount != 16'hFFFF) readCount <= readCount + 16'd1;
            end
`endif
          end else begin
            cnt <= cnt + 1'b1;
          end
        end

        DONE: begin
          state <= IDLE;
        end

        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_sram_controller.sv
// Self-checking bench for sram_controller (default parameters).
// A behavioural 16-bit SRAM device sits on the pins; a word-level reference
// memory predicts load results, and every access is checked cycle by cycle.
module tb_sram_controller;

  localparam int unsigned AW = 18;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  sram_controller_if bus ();

  logic [AW-1:0] sramAddr;
  logic [15:0]   sramDqOut;
  logic [15:0]   sramDqIn;
  logic          sramDqOe, sramWeN, sramOeN, sramCeN, sramUbN, sramLbN;
  logic [1:0]    dbg_state;
`ifdef SRAM_STATS_EN
  logic [15:0]   readCount, writeCount;
`endif

  sram_controller dut (
    .clk       (clk),
    .rst       (rst),
    .bus       (bus),
    .sramAddr  (sramAddr),
    .sramDqOut (sramDqOut),
    .sramDqIn  (sramDqIn),
    .sramDqOe  (sramDqOe),
    .sramWeN   (sramWeN),
    .sramOeN   (sramOeN),
    .sramCeN   (sramCeN),
    .sramUbN   (sramUbN),
    .sramLbN   (sramLbN),
    .dbg_state (dbg_state)
`ifdef SRAM_STATS_EN
    ,
    .readCount (readCount),
    .writeCount(writeCount)
`endif
  );

  // ---------------- SRAM device ----------------
  logic [15:0] sram_mem [0:(1<<AW)-1];

  always_comb begin
    sramDqIn = 16'h5A5A;
    if (!sramCeN && !sramOeN) sramDqIn = sram_mem[sramAddr];
  end

  always @(negedge clk) begin
    if (!sramCeN && !sramWeN) sram_mem[sramAddr] <= sramDqOut;
  end

  // ---------------- scoreboard ----------------
  logic [31:0] ref_words [int unsigned];
  logic [31:0] exp_q [$];
  logic [31:0] exp_rd;
  bit          exp_rd_valid;
  int          rd_total, wr_total;
  int          n_tests, n_fail;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%h exp=%h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic int unsigned word_of(input logic [31:0] addr);
    return ((addr - 32'd1024) >> 2) % (1 << (AW - 1));
  endfunction

  task automatic check_idle_pins(input string tag);
    check({tag, "_ce"},   32'(sramCeN), 32'd1);
    check({tag, "_we"},   32'(sramWeN), 32'd1);
    check({tag, "_oe"},   32'(sramOeN), 32'd1);
    check({tag, "_ublb"}, 32'({sramUbN, sramLbN}), 32'd3);
    check({tag, "_dqoe"}, 32'(sramDqOe), 32'd0);
  endtask

  // ---------------- driver tasks ----------------
  // One full access starting at the next edge; when scramble is set the
  // request inputs are randomised while busy and must have no effect.
  task automatic access(input logic rd, input logic wr, input logic [31:0] addr,
                        input logic [31:0] data, input bit scramble);
    int unsigned idx;
    logic        is_wr;
    logic        half;
    idx   = word_of(addr);
    is_wr = wr;
    @(posedge clk); #1;
    bus.rdEn = rd; bus.wrEn = wr; bus.address = addr; bus.writeData = data;
    @(negedge clk);
    check("req_ready", 32'(bus.ready), 32'd0);
    if (is_wr) begin
      ref_words[idx] = data;
      wr_total++;
    end else begin
      exp_q.push_back(ref_words.exists(idx) ? ref_words[idx] : 32'h0);
      rd_total++;
    end
    for (int c = 1; c <= 4; c++) begin
      @(posedge clk); #1;
      if (scramble) begin
        bus.address   = $urandom;
        bus.writeData = $urandom;
        bus.rdEn      = 1'($urandom_range(0, 1));
        bus.wrEn      = 1'($urandom_range(0, 1));
      end
      @(negedge clk);
      half = (c > 2);
      check("busy_ready", 32'(bus.ready), 32'd0);
      check("addr", 32'(sramAddr), 32'(idx * 2 + 32'(half)));
      check("ce", 32'(sramCeN), 32'd0);
      check("ublb", 32'({sramUbN, sramLbN}), 32'd0);
      check("we", 32'(sramWeN), 32'(!is_wr));
      check("oe", 32'(sramOeN), 32'(is_wr));
      check("dqoe", 32'(sramDqOe), 32'(is_wr));
      if (is_wr) check("dq", 32'(sramDqOut), half ? 32'(data[31:16]) : 32'(data[15:0]));
    end
    @(posedge clk); #1;
    @(negedge clk);
    check("done_ready", 32'(bus.ready), 32'd1);
    check_idle_pins("done");
    if (!is_wr) begin
      exp_rd       = exp_q.pop_front();
      exp_rd_valid = 1'b1;
    end
    if (exp_rd_valid) check("rdata", bus.readData, exp_rd);
  endtask

  task automatic idle_cycle();
    @(posedge clk); #1;
    bus.rdEn = 1'b0; bus.wrEn = 1'b0;
    @(negedge clk);
    check("idle_ready", 32'(bus.ready), 32'd1);
    check_idle_pins("idle");
  endtask

  // ---------------- main sequence ----------------
  initial begin
    logic [31:0] a, d;
    logic        r, w;
    n_tests = 0; n_fail = 0; rd_total = 0; wr_total = 0;
    exp_rd = 32'h0; exp_rd_valid = 1'b1;
    for (int i = 0; i < (1 << AW); i++) sram_mem[i] = 16'h0000;
    bus.rdEn = 1'b0; bus.wrEn = 1'b0; bus.address = '0; bus.writeData = '0;

    // reset state
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_ready", 32'(bus.ready), 32'd1);
    check("rst_rdata", bus.readData, 32'h0);
    check("rst_addr", 32'(sramAddr), 32'h0);
    check("rst_dqout", 32'(sramDqOut), 32'h0);
    check_idle_pins("rst");
`ifdef SRAM_STATS_EN
    check("rst_rcnt", 32'(readCount), 32'h0);
    check("rst_wcnt", 32'(writeCount), 32'h0);
`endif
    #1 bus.rdEn = 1'b1;
    #1 check("rst_pending_ready", 32'(bus.ready), 32'd0);
    @(posedge clk); #1;
    rst = 1'b0; bus.rdEn = 1'b0;
    @(negedge clk);
    check("post_rst_ready", 32'(bus.ready), 32'd1);

    // directed cases
    access(1'b0, 1'b1, 32'd1024, 32'hDEADBEEF, 1'b0); idle_cycle();
    access(1'b1, 1'b0, 32'd1024, 32'h0, 1'b0);        idle_cycle();
    access(1'b0, 1'b1, 32'd1030, 32'hCAFEF00D, 1'b0); idle_cycle();
    access(1'b1, 1'b0, 32'd1028, 32'h0, 1'b0);        idle_cycle();
    access(1'b1, 1'b1, 32'd1024, 32'h12345678, 1'b0); idle_cycle();
    // back-to-back, requests never dropped
    access(1'b0, 1'b1, 32'd1040, 32'hA5A55A5A, 1'b0);
    access(1'b1, 1'b0, 32'd1040, 32'h0, 1'b0);
    access(1'b1, 1'b0, 32'd1024, 32'h0, 1'b0);        idle_cycle();
    // wrap below the base address
    access(1'b0, 1'b1, 32'd0, 32'h0BADF00D, 1'b0);
    access(1'b1, 1'b0, 32'd3, 32'h0, 1'b1);           idle_cycle();

    // randomised traffic
    for (int n = 0; n < 60; n++) begin
      a = 32'd1024 + 32'($urandom_range(0, 63)) * 4 + 32'($urandom_range(0, 3));
      d = $urandom;
      w = 1'($urandom_range(0, 1));
      r = w ? 1'($urandom_range(0, 1)) : 1'b1;
      access(r, w, a, d, 1'b1);
      if ($urandom_range(0, 2) == 0) idle_cycle();
    end
    idle_cycle();

    // reset in cycle 3 of a write
    @(posedge clk); #1;
    bus.wrEn = 1'b1; bus.rdEn = 1'b0; bus.address = 32'd1024 + 32'd4 * 32'd5000;
    bus.writeData = 32'h11223344;
    @(posedge clk); @(posedge clk);
    @(posedge clk); #1 rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    check("midrst_ready_req", 32'(bus.ready), 32'd0);
    check_idle_pins("midrst");
    rst = 1'b0; bus.wrEn = 1'b0;
    #1 check("midrst_ready_noreq", 32'(bus.ready), 32'd1);
`ifdef SRAM_STATS_EN
    check("midrst_rcnt", 32'(readCount), 32'h0);
    check("midrst_wcnt", 32'(writeCount), 32'h0);
`endif
    rd_total = 0; wr_total = 0; exp_rd_valid = 1'b0;
    idle_cycle();
    access(1'b1, 1'b0, 32'd1036, 32'h0, 1'b0);
    idle_cycle();

`ifdef SRAM_STATS_EN
    check("final_rcnt", 32'(readCount), 32'(rd_total));
    check("final_wcnt", 32'(writeCount), 32'(wr_total));
`endif
    check("exp_q_empty", 32'(exp_q.size()), 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  // global time bound
  initial begin
    #2000000;
    $display("FAIL timeout tests=%0d", n_tests);
    $fatal(1, "timeout");
  end

endmodule
